// File: rtl/key_sched_ctrl.sv
// Round-robin load controller in front of key_gen: arbitrates A/B key loads,
// runs key_gen with a bounded wait and caches the last {key, mode} it produced.
module key_sched_ctrl #(
  parameter int TIMEOUT = 63
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         req_a,
  input  logic [63:0]  key_a,
  input  logic         mode_a,
  output logic         ack_a,
  input  logic         req_b,
  input  logic [63:0]  key_b,
  input  logic         mode_b,
  output logic         ack_b,
  input  logic         flush,
  output logic [63:0]  kg_init_key,
  output logic         kg_encrypt_decrypt,
  output logic         kg_valid_i,
  input  logic         kg_valid_o,
  input  logic [767:0] kg_round_keys,
  output logic [767:0] round_keys,
  output logic         keys_valid,
  output logic         keys_owner,
  output logic         busy,
  output logic         timeout_err,
  output logic [1:0]   o_dbg_state
);

  // Handshake: a requester raises req with key/mode stable and holds it until
  // the one-cycle ack; it drops req on the edge that samples ack. A request
  // that times out gets no ack and simply stays pending for re-arbitration.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  state_t          r_state;
  logic            r_sel;
  logic            r_last_grant;
  logic [63:0]     r_tag_key;
  logic            r_tag_mode;
  logic            r_tag_valid;
  logic [CW-1:0]   r_cnt;
  logic [63:0]     r_kg_key;
  logic            r_kg_mode;
  logic            r_kg_valid_i;
  logic [767:0]    r_round_keys;
  logic            r_keys_valid;
  logic            r_keys_owner;
  logic            r_timeout_err;
  logic            r_ack_a;
  logic            r_ack_b;

  logic            w_any_req;
  logic            w_win;
  logic [63:0]     w_key;
  logic            w_mode;
  logic            w_hit;
  logic            w_capture;

  assign w_any_req = req_a | req_b;
  assign w_win     = (req_a && req_b) ? ~r_last_grant : req_b;
  assign w_key     = w_win ? key_b : key_a;
  assign w_mode    = w_win ? mode_b : mode_a;
  assign w_hit     = r_tag_valid && (w_key == r_tag_key) && (w_mode == r_tag_mode);
  assign w_capture = (r_state == S_RUN) && kg_valid_o;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= S_IDLE;
      r_sel         <= 1'b0;
      r_last_grant  <= 1'b1;
      r_tag_key     <= '0;
      r_tag_mode    <= 1'b0;
      r_tag_valid   <= 1'b0;
      r_cnt         <= '0;
      r_kg_key      <= '0;
      r_kg_mode     <= 1'b0;
      r_kg_valid_i  <= 1'b0;
      r_round_keys  <= '0;
      r_keys_valid  <= 1'b0;
      r_keys_owner  <= 1'b0;
      r_timeout_err <= 1'b0;
      r_ack_a       <= 1'b0;
      r_ack_b       <= 1'b0;
    end else begin
      r_ack_a <= 1'b0;
      r_ack_b <= 1'b0;
      // A capture on the same edge as flush keeps the freshly loaded keys.
      if (flush && !w_capture) begin
        r_tag_valid  <= 1'b0;
        r_keys_valid <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_sel        <= w_win;
            r_last_grant <= w_win;
            if (w_hit) begin
              r_ack_a <= ~w_win;
              r_ack_b <= w_win;
              r_state <= S_DONE;
            end else begin
              r_kg_key     <= w_key;
              r_kg_mode    <= w_mode;
              r_kg_valid_i <= 1'b1;
              r_keys_valid <= 1'b0;
              r_cnt        <= '0;
              r_state      <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (kg_valid_o) begin
            r_round_keys  <= kg_round_keys;
            r_tag_key     <= r_kg_key;
            r_tag_mode    <= r_kg_mode;
            r_tag_valid   <= 1'b1;
            r_keys_valid  <= 1'b1;
            r_keys_owner  <= r_sel;
            r_timeout_err <= 1'b0;
            r_kg_valid_i  <= 1'b0;
            r_ack_a       <= ~r_sel;
            r_ack_b       <= r_sel;
            r_state       <= S_DONE;
          end else if (r_cnt == CNT_MAX) begin
            r_timeout_err <= 1'b1;
            r_tag_valid   <= 1'b0;
            r_kg_valid_i  <= 1'b0;
            r_state       <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          // On a miss this rewrites the owner already set at capture.
          r_keys_owner <= r_sel;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack_a              = r_ack_a;
  assign ack_b              = r_ack_b;
  assign kg_init_key        = r_kg_key;
  assign kg_encrypt_decrypt = r_kg_mode;
  assign kg_valid_i         = r_kg_valid_i;
  assign round_keys         = r_round_keys;
  assign keys_valid         = r_keys_valid;
  assign keys_owner         = r_keys_owner;
  assign timeout_err        = r_timeout_err;
  assign busy               = (r_state != S_IDLE);
  assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Bench for key_sched_ctrl: a transaction-level model expands each load into
// an expected per-cycle trace that is compared against the DUT cycle by cycle.
module tb_key_sched_ctrl;

  localparam int          TB_TO    = 16;
  localparam logic [63:0] HANG_KEY = 64'hDEAD_0000_BEEF_0001;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic         req_a = 1'b0, req_b = 1'b0;
  logic [63:0]  key_a = '0, key_b = '0;
  logic         mode_a = 1'b0, mode_b = 1'b0;
  logic         flush = 1'b0;
  logic         ack_a, ack_b;
  logic [63:0]  kg_init_key;
  logic         kg_encrypt_decrypt, kg_valid_i, kg_valid_o;
  logic [767:0] kg_round_keys, round_keys;
  logic         keys_valid, keys_owner, busy, timeout_err;
  logic [1:0]   dbg_state;

  key_sched_ctrl #(.TIMEOUT(TB_TO)) dut (
    .clk(clk), .rstn(rstn),
    .req_a(req_a), .key_a(key_a), .mode_a(mode_a), .ack_a(ack_a),
    .req_b(req_b), .key_b(key_b), .mode_b(mode_b), .ack_b(ack_b),
    .flush(flush),
    .kg_init_key(kg_init_key), .kg_encrypt_decrypt(kg_encrypt_decrypt),
    .kg_valid_i(kg_valid_i), .kg_valid_o(kg_valid_o), .kg_round_keys(kg_round_keys),
    .round_keys(round_keys), .keys_valid(keys_valid), .keys_owner(keys_owner),
    .busy(busy), .timeout_err(timeout_err), .o_dbg_state(dbg_state)
  );

  // ---------------- key_gen stub ----------------
  function automatic logic [767:0] bundle(input logic [63:0] k, input logic m);
    logic [767:0] b;
    for (int i = 0; i < 12; i++)
      b[i*64 +: 64] = k ^ (64'(i + 1) * 64'h9E3779B97F4A7C15) ^ {64{m}};
    return b;
  endfunction

  int         stub_lat = 0;
  logic [7:0] stub_cnt;
  always @(posedge clk or negedge rstn)
    if (!rstn) stub_cnt <= 8'd0;
    else       stub_cnt <= kg_valid_i ? stub_cnt + 8'd1 : 8'd0;
  assign kg_valid_o    = kg_valid_i && (kg_init_key != HANG_KEY) && (int'(stub_cnt) == stub_lat);
  assign kg_round_keys = bundle(kg_init_key, kg_encrypt_decrypt);

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [3:0]   sig;      // {ack_a, ack_b, kg_valid_i, busy}
    logic         chk_key;
    logic [63:0]  key;
    logic         mode;
    logic         chk_meta;
    logic [767:0] rk;
    logic         kv;
    logic         owner;
    logic         terr;
    logic         fl;
    logic         drop_a;
    logic         drop_b;
  } ent_t;
  localparam int W = $bits(ent_t);
  logic [W-1:0] exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [767:0] obs, input logic [767:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit           m_last = 1'b1;
  bit           m_tag_valid = 1'b0;
  logic [63:0]  m_tag_key = '0;
  bit           m_tag_mode = 1'b0;
  logic [767:0] m_rk = '0;
  bit           m_kv = 1'b0;
  bit           m_owner = 1'b0;
  bit           m_terr = 1'b0;

  task automatic model_reset();
    m_last = 1'b1; m_tag_valid = 1'b0; m_tag_key = '0; m_tag_mode = 1'b0;
    m_rk = '0; m_kv = 1'b0; m_owner = 1'b0; m_terr = 1'b0;
  endtask

  function automatic ent_t meta_ent();
    ent_t e;
    e = '0;
    e.chk_meta = 1'b1; e.rk = m_rk; e.kv = m_kv; e.owner = m_owner; e.terr = m_terr;
    return e;
  endfunction

  // Expand the loads of the currently pending requesters into a cycle trace.
  task automatic build(input bit pa, input bit pb, input bit fl);
    bit [1:0]    pend;
    int          tos[2];
    bit          w, drop, hit;
    logic [63:0] k;
    bit          m;
    int          lat;
    ent_t        e;
    pend[0] = pa; pend[1] = pb; tos[0] = 0; tos[1] = 0;
    while (pend != 2'b00) begin
      w      = (pend == 2'b11) ? !m_last : pend[1];
      m_last = w;
      k      = w ? key_b : key_a;
      m      = w ? mode_b : mode_a;
      hit    = m_tag_valid && (k == m_tag_key) && (m == m_tag_mode);
      if (hit) begin
        m_owner = w;
        e = '0; e.sig = {!w, w, 1'b0, 1'b1}; e.drop_a = !w; e.drop_b = w;
        exp_q.push_back(e);
        pend[w] = 1'b0;
        exp_q.push_back(meta_ent());
      end else begin
        m_kv = 1'b0;
        lat  = (k == HANG_KEY) ? TB_TO + 1 : stub_lat;
        if (lat <= TB_TO) begin
          for (int c = 0; c <= lat; c++) begin
            e = '0; e.sig = 4'b0011; e.chk_key = (c == 0); e.key = k; e.mode = m; e.fl = fl;
            exp_q.push_back(e);
          end
          m_tag_valid = 1'b1; m_tag_key = k; m_tag_mode = m;
          m_rk = bundle(k, m); m_kv = 1'b1; m_owner = w; m_terr = 1'b0;
          e = '0; e.sig = {!w, w, 1'b0, 1'b1}; e.drop_a = !w; e.drop_b = w;
          exp_q.push_back(e);
          pend[w] = 1'b0;
          exp_q.push_back(meta_ent());
        end else begin
          tos[w]++;
          drop = !pend[!w] || (tos[w] == 2);
          for (int c = 0; c <= TB_TO; c++) begin
            e = '0; e.sig = 4'b0011; e.chk_key = (c == 0); e.key = k; e.mode = m; e.fl = fl;
            if (c == TB_TO && drop) begin e.drop_a = !w; e.drop_b = w; end
            exp_q.push_back(e);
          end
          m_tag_valid = 1'b0; m_terr = 1'b1;
          if (drop) pend[w] = 1'b0;
          exp_q.push_back(meta_ent());
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Entered and left #1 after a rising edge with the DUT idle.
  task automatic play(input bit pa, input bit pb, input bit fl);
    ent_t e;
    build(pa, pb, fl);
    req_a = pa; req_b = pb;
    @(posedge clk); #1;
    while (exp_q.size() > 0) begin
      e = ent_t'(exp_q.pop_front());
      flush = e.fl;
      @(negedge clk);
      check("sig", {ack_a, ack_b, kg_valid_i, busy}, e.sig);
      if (e.chk_key) begin
        check("kg_key", kg_init_key, e.key);
        check("kg_mode", kg_encrypt_decrypt, e.mode);
      end
      if (e.chk_meta) begin
        check("round_keys", round_keys, e.rk);
        check("keys_valid", keys_valid, e.kv);
        check("keys_owner", keys_owner, e.owner);
        check("timeout_err", timeout_err, e.terr);
      end
      @(posedge clk); #1;
      if (e.drop_a) req_a = 1'b0;
      if (e.drop_b) req_b = 1'b0;
    end
    flush = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    m_tag_valid = 1'b0; m_kv = 1'b0;
    @(negedge clk);
    check("flush_kv", keys_valid, m_kv);
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // ---------------- main sequence ----------------
  logic [63:0] pool[4];

  initial begin
    for (int i = 0; i < 4; i++) pool[i] = rnd64();
    repeat (2) @(negedge clk);
    check("rst_sig", {ack_a, ack_b, kg_valid_i, busy}, 4'b0000);
    check("rst_rk", round_keys, '0);
    check("rst_meta", {keys_valid, keys_owner, timeout_err}, 3'b000);
    check("rst_kg", {kg_init_key, kg_encrypt_decrypt}, '0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // single miss, latency 16, then hit from B, then decrypt miss
    key_a = 64'h133457799BBCDFF1; mode_a = 1'b1; stub_lat = 16;
    play(1'b1, 1'b0, 1'b0);
    key_b = 64'h133457799BBCDFF1; mode_b = 1'b1;
    play(1'b0, 1'b1, 1'b0);
    mode_b = 1'b0; stub_lat = 5;
    play(1'b0, 1'b1, 1'b0);

    // contention, twice
    key_a = pool[0]; mode_a = 1'b1; key_b = pool[1]; mode_b = 1'b0; stub_lat = 3;
    play(1'b1, 1'b1, 1'b0);
    key_a = pool[2]; mode_a = 1'b0; key_b = pool[3]; mode_b = 1'b1; stub_lat = 7;
    play(1'b1, 1'b1, 1'b0);

    // zero latency
    key_a = 64'h0F0F_1234_5678_F0F0; mode_a = 1'b1; stub_lat = 0;
    play(1'b1, 1'b0, 1'b0);

    // timeout on A with B pending, then a clean load
    key_b = 64'hCAFE_F00D_0000_0001; mode_b = 1'b1; stub_lat = 2;
    play(1'b0, 1'b1, 1'b0);
    key_a = HANG_KEY; key_b = pool[0]; mode_b = 1'b1;
    play(1'b1, 1'b1, 1'b0);
    key_a = HANG_KEY; mode_a = 1'b0;
    play(1'b1, 1'b0, 1'b0);
    key_a = pool[1]; mode_a = 1'b1; stub_lat = 4;
    play(1'b1, 1'b0, 1'b0);

    // flush in idle turns the cached key into a miss
    key_a = m_tag_key; mode_a = m_tag_mode;
    do_flush();
    play(1'b1, 1'b0, 1'b0);

    // flush held across RUN including the capture edge
    key_a = 64'h7777_0000_1111_2222; mode_a = 1'b0; stub_lat = 6;
    play(1'b1, 1'b0, 1'b1);
    key_b = 64'h7777_0000_1111_2222; mode_b = 1'b0;
    play(1'b0, 1'b1, 1'b0);

    // randomized loads
    for (int it = 0; it < 40; it++) begin
      bit pa, pb, fl;
      if ($urandom_range(0, 9) == 0) do_flush();
      pa = $urandom_range(0, 1); pb = $urandom_range(0, 1);
      if (!pa && !pb) pa = 1'b1;
      key_a  = ($urandom_range(0, 7) == 0) ? HANG_KEY : pool[$urandom_range(0, 3)];
      key_b  = ($urandom_range(0, 7) == 0) ? HANG_KEY : pool[$urandom_range(0, 3)];
      mode_a = $urandom_range(0, 1); mode_b = $urandom_range(0, 1);
      stub_lat = $urandom_range(0, TB_TO);
      fl = ($urandom_range(0, 5) == 0);
      play(pa, pb, fl);
    end

    // reset in the middle of RUN
    key_a = 64'h5555_AAAA_5555_AAAA; mode_a = 1'b0; stub_lat = 10;
    do_flush();
    req_a = 1'b1;
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_vi", kg_valid_i, 1'b1);
    #2 rstn = 1'b0;
    #1;
    check("rst_async", {kg_valid_i, busy}, 2'b00);
    req_a = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst_noack", {ack_a, ack_b}, 2'b00);
    check("rst2_rk", round_keys, m_rk);
    check("rst2_meta", {keys_valid, keys_owner, timeout_err}, {m_kv, m_owner, m_terr});
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_noack", {ack_a, ack_b, busy}, 3'b000);
    @(posedge clk); #1;

    // recovery: A wins the first tie again
    key_a = pool[2]; mode_a = 1'b1; key_b = pool[3]; mode_b = 1'b0; stub_lat = 1;
    play(1'b1, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/key_sched_ctrl.md
# key_sched_ctrl

Arbitrating controller in front of the `key_gen` round-key generator. It accepts key-load requests from two requesters (A, B), picks one round-robin, and drives `key_gen` with the chosen 64-bit key and direction. It waits a variable number of cycles for `key_gen` to return its result, then latches the 768-bit round-key bundle and acknowledges the requester. A one-entry tag cache skips regeneration when the same key and mode are requested again.

## Interface
- `TIMEOUT`, default 63: maximum number of cycles spent in RUN waiting for `kg_valid_o`; must be ≥ 1.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rstn` input 1: reset, asynchronous and active-low.
- `req_a` / `req_b` input 1: load request; held high until the matching ack.
- `key_a` / `key_b` input 64: key; must be stable while the matching req is high.
- `mode_a` / `mode_b` input 1: 1 = encrypt, 0 = decrypt; stable while req is high.
- `ack_a` / `ack_b` output 1: one-cycle completion pulse.
- `flush` input 1: invalidates the cached key and the output bundle.
- `kg_init_key` output 64: key driven to `key_gen`.
- `kg_encrypt_decrypt` output 1: mode driven to `key_gen`.
- `kg_valid_i` output 1: held high for the whole RUN state.
- `kg_valid_o` input 1: `key_gen` result valid.
- `kg_round_keys` input 768: `key_gen` round-key bundle.
- `round_keys` output 768: latched bundle.
- `keys_valid` output 1: `round_keys` holds keys for `{tag_key, tag_mode}`.
- `keys_owner` output 1: requester of the last load (0 = A, 1 = B).
- `busy` output 1: state ≠ IDLE.
- `timeout_err` output 1: sticky flag, set on timeout.

## Operation
- **States:** IDLE, RUN, DONE.
- **Internal registers:**
  - `sel` (granted requester).
  - `last_grant` (resets to 1, so A wins the first tie).
  - `tag_key[63:0]`, `tag_mode`, `tag_valid`.
  - `cnt` of width `$clog2(TIMEOUT+1)`.
- **Arbitration (IDLE, any req high):**
  - Only one req high: grant it.
  - Both high: grant the requester ≠ `last_grant`.
  - On every grant: `sel` ← winner, `last_grant` ← winner.
- **IDLE, hit** (`tag_valid` and the winner's key and mode both equal the tag): go to DONE with no `key_gen` activity.
- **IDLE, miss:**
  - Register the winner's key and mode onto `kg_init_key` / `kg_encrypt_decrypt`.
  - `keys_valid` ← 0, `cnt` ← 0, go to RUN.
- **RUN:**
  - `kg_valid_i` = 1 and the key/mode outputs are held constant.
  - Every edge: if `kg_valid_o` = 1, then:
    - `round_keys` ← `kg_round_keys`;
    - tag ← {key, mode}, `tag_valid` ← 1, `keys_valid` ← 1;
    - `keys_owner` ← `sel`, `timeout_err` ← 0;
    - go to DONE.
  - Else if `cnt` == `TIMEOUT`: `timeout_err` ← 1, `tag_valid` ← 0, go to IDLE with no ack; the request stays pending and is re-arbitrated.
  - Else `cnt` ← `cnt` + 1.
- **DONE:** `ack_sel` = 1 for exactly one cycle, then go to IDLE. On a hit, `keys_owner` ← `sel` in DONE.
- `kg_valid_o` is ignored outside RUN. `kg_valid_o` already high in the first RUN cycle (combinational `key_gen`) is legal and is captured on that edge.
- **Flush:**
  - On any edge, `flush` = 1 clears `tag_valid` and `keys_valid`.
  - If `flush` coincides with a RUN capture, the capture wins (the new key stays valid).
  - `flush` never aborts RUN.

## Timing
- **Reset values:** state IDLE; all outputs 0, including `round_keys` = 0, `keys_owner` = 0, `timeout_err` = 0 and `kg_valid_i` = 0. `last_grant` = 1, `tag_valid` = 0.
- **Reset mid-RUN:** `kg_valid_i` drops asynchronously and no ack is issued.
- **Miss latency:**
  - req sampled at edge 0; RUN during cycles 1..1+L, where L = number of cycles before `kg_valid_o`.
  - Capture at edge 1+L; `ack` and `keys_valid` are high in cycle 2+L.
  - Minimum (L = 0): ack in cycle 2.
- **Hit latency:** ack in cycle 1 after the req is sampled.
- **Requester handshake:**
  - The requester deasserts req on the edge that samples ack high.
  - DONE is always followed by at least one IDLE cycle, so a registered req drop is never re-granted.
- **Back-to-back:** when both requesters are pending, grants alternate A, B, A, …
- **Timeout:** RUN lasts `TIMEOUT`+1 cycles before returning to IDLE.

## Test plan
- **Single miss:** with a `key_gen` stub of latency 16, reset, then `req_a` = 1, `key_a` = 0x133457799BBCDFF1, `mode_a` = 1.
  - `kg_valid_i` is high for cycles 1..17.
  - `ack_a` pulses in cycle 18.
  - `round_keys` equals the stub bundle, `keys_valid` = 1, `keys_owner` = 0.
- **Hit:** repeat the same key and mode on `req_b`.
  - `kg_valid_i` stays 0 and `ack_b` pulses 1 cycle after the req is sampled.
  - `keys_owner` = 1 and `round_keys` is unchanged.
  - Repeat with `mode_b` = 0: it is a miss, and `kg_encrypt_decrypt` = 0.
- **Contention:** A and B both held high with distinct keys.
  - First grant goes to A, then B, then A.
  - Each ack is exactly one cycle long, and `keys_owner` follows the grant order.
- **Zero latency:** with a combinational stub (`kg_valid_o` = `kg_valid_i`), RUN lasts 1 cycle and ack arrives in cycle 2.
- **Timeout:** stub never asserts `kg_valid_o`, `TIMEOUT` = 3.
  - RUN lasts 4 cycles, then `timeout_err` = 1, `keys_valid` = 0, and there is no ack.
  - With B also pending, B is granted next.
  - A later successful load clears `timeout_err`.
- **Flush and reset:**
  - `flush` in IDLE after a load gives `keys_valid` = 0, and the same key then misses.
  - `flush` on the capture edge leaves `keys_valid` = 1.
  - `rstn` low mid-RUN immediately gives `kg_valid_i` = 0 and `busy` = 0, with no ack.
